// File: rtl/spart.sv
// SPART bus responder and serial engine: register decode, baud generator,
// 8N1 transmitter with holding buffer, 16x-oversampling receiver.
module spart #(
  parameter logic [15:0] DB_RESET = 16'h0516
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  // Bus: a cycle with iocs=1 is one access; reads drive databus combinationally,
  // writes are captured on the clock edge that ends the cycle.
  logic wr_en, rd_en, wr_tx, wr_dbl, wr_dbh, rd_rx, rd_first;
  logic [7:0] rd_data;

  logic [15:0] divisor_q, divisor_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic        tick;

  state_e      tx_state_q, tx_state_d;
  logic        tbr_q, tbr_d;
  logic [7:0]  tx_buf_q, tx_buf_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [3:0]  tx_tick_q, tx_tick_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        txd_q, txd_d;

  state_e      rx_state_q, rx_state_d;
  logic        rx_s1_q, rx_s1_d;
  logic        rx_s2_q, rx_s2_d;
  logic        rx_prev_q, rx_prev_d;
  logic [3:0]  rx_tick_q, rx_tick_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_buf_q, rx_buf_d;
  logic        rx_load;
  logic        rda_q, rda_d;
  logic        rd_prev_q, rd_prev_d;

  assign wr_en  = iocs & ~iorw;
  assign rd_en  = iocs & iorw;
  assign wr_tx  = wr_en && (ioaddr == 2'b00);
  assign wr_dbl = wr_en && (ioaddr == 2'b10);
  assign wr_dbh = wr_en && (ioaddr == 2'b11);
  assign rd_rx  = rd_en && (ioaddr == 2'b00);
  // rda clears only on the first cycle of a held read
  assign rd_first  = rd_rx & ~rd_prev_q;
  assign rd_prev_d = rd_rx;

  always_comb begin
    rd_data = 8'h00;
    case (ioaddr)
      2'b00:   rd_data = rx_buf_q;
      2'b01:   rd_data = {6'b0, tbr_q, rda_q};
      default: rd_data = 8'h00;
    endcase
  end

  assign databus = rd_en ? rd_data : 8'hzz;

  assign tick = (baud_cnt_q == 16'd0);

  always_comb begin
    divisor_d = divisor_q;
    if (wr_dbl) divisor_d[7:0]  = databus;
    if (wr_dbh) divisor_d[15:8] = databus;
    if (wr_dbl || wr_dbh)
      baud_cnt_d = divisor_d;
    else if (tick)
      baud_cnt_d = divisor_q;
    else
      baud_cnt_d = baud_cnt_q - 16'd1;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tbr_d      = tbr_q;
    tx_buf_d   = tx_buf_q;
    tx_shift_d = tx_shift_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    txd_d      = txd_q;
    // Loads only land in an empty buffer, and IDLE only drains a full one,
    // so the two never update tbr on the same edge.
    if (wr_tx && tbr_q) begin
      tx_buf_d = databus;
      tbr_d    = 1'b0;
    end
    case (tx_state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (!tbr_q) begin
          tx_shift_d = tx_buf_q;
          tbr_d      = 1'b1;
          tx_tick_d  = 4'd0;
          tx_bit_d   = 3'd0;
          txd_d      = 1'b0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tx_tick_d = tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            txd_d      = tx_shift_q[0];
            tx_state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          tx_tick_d = tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            if (tx_bit_q == 3'd7) begin
              txd_d      = 1'b1;
              tx_state_d = ST_STOP;
            end else begin
              tx_bit_d   = tx_bit_q + 3'd1;
              tx_shift_d = {1'b0, tx_shift_q[7:1]};
              txd_d      = tx_shift_q[1];
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          tx_tick_d = tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) tx_state_d = ST_IDLE;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_s1_d    = rxd;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_buf_d   = rx_buf_q;
    rx_load    = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_tick_d  = 4'd0;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        // Half a bit in: still low means a real start bit, else a glitch
        if (tick) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd7) begin
            rx_tick_d  = 4'd0;
            rx_bit_d   = 3'd0;
            rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            if (rx_s2_q) begin
              rx_buf_d = rx_shift_q;
              rx_load  = 1'b1;
            end
            rx_state_d = ST_IDLE;
          end
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // A byte landing on the same edge as a read keeps rda set
  always_comb begin
    rda_d = rda_q;
    if (rd_first) rda_d = 1'b0;
    if (rx_load)  rda_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor_q  <= DB_RESET;
      baud_cnt_q <= DB_RESET;
      tx_state_q <= ST_IDLE;
      tbr_q      <= 1'b1;
      tx_buf_q   <= 8'h00;
      tx_shift_q <= 8'h00;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      txd_q      <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_buf_q   <= 8'h00;
      rda_q      <= 1'b0;
      rd_prev_q  <= 1'b0;
    end else begin
      divisor_q  <= divisor_d;
      baud_cnt_q <= baud_cnt_d;
      tx_state_q <= tx_state_d;
      tbr_q      <= tbr_d;
      tx_buf_q   <= tx_buf_d;
      tx_shift_q <= tx_shift_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      txd_q      <= txd_d;
      rx_state_q <= rx_state_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
      rda_q      <= rda_d;
      rd_prev_q  <= rd_prev_d;
    end
  end

  assign txd = txd_q;
  assign tbr = tbr_q;
  assign rda = rda_q;

endmodule

// File: doc/spart.md
Name: spart

Overview:
- Bus-side responder and serial engine of the SPART (special-purpose asynchronous receiver/transmitter).
- Answers the chip-select/read-write/address bus issued by the processor-side driver and owns the 16-bit baud divisor.
- Contains an 8N1 transmitter with a one-byte holding buffer and a 16x-oversampling receiver with a one-byte receive buffer.
- Sits between the driver and the board TxD/RxD pins.

Parameters:
- DB_RESET, 16'h0516, divisor loaded at reset (4800 baud at 100 MHz, 16x).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- iocs  in  1  chip select; a bus access is valid only when high
- iorw  in  1  1 = read from SPART, 0 = write to SPART
- ioaddr  in  2  register address
- databus  inout  8  bidirectional data bus
- rda  out  1  receive data available
- tbr  out  1  transmit buffer ready (holding buffer empty)
- txd  out  1  serial transmit line, idle high
- rxd  in  1  serial receive line, asynchronous

Behaviour:
- Reset (rst=0, async) values:
  - txd=1, tbr=1, rda=0.
  - Divisor=DB_RESET, baud counter=DB_RESET.
  - TX and RX FSMs in IDLE; databus released (Z).
  - Reset mid-frame aborts the frame immediately; txd returns to 1.
- Register map, decoded only when iocs=1:
  - 00 write: load tx buffer. Accepted only if tbr=1; tbr=0 the next cycle. If tbr=0 the write is ignored.
  - 00 read: drive rx buffer. rda clears at the clock edge ending the first read cycle. Holding iocs for additional cycles is harmless; the data value stays stable.
  - 01 read: drive {6'b0, tbr, rda}. 01 write is ignored.
  - 10 write: divisor[7:0]. 11 write: divisor[15:8]. Either write also reloads the baud counter with the new full divisor. Reads of 10/11 drive 8'h00.
- databus:
  - Driven combinationally only while iocs=1 and iorw=1.
  - High-Z at all other times, including any cycle where iocs=0.
- Baud generator:
  - 16-bit down-counter. At 0 it emits a one-cycle tick and reloads the divisor.
  - Tick period = divisor+1 clocks. Divisor 0 gives a tick every clock.
  - Free-running and shared by TX and RX. One bit = 16 ticks.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: if the holding buffer is full, move it to the shifter, set tbr=1 on the same edge, go to START.
  - START: txd=0 for 16 ticks. DATA: 8 bits, LSB first, 16 ticks each. STOP: txd=1 for 16 ticks, then IDLE.
  - The holding buffer can be refilled during a frame. The next frame starts the cycle after STOP ends, with no extra idle bit.
  - The first start bit begins within 1 clock of the load; it is not aligned to a tick. Bit timing counts ticks from the next tick.
- RX FSM (IDLE, START, DATA, STOP):
  - rxd passes through a 2-flop synchronizer.
  - IDLE: a synchronized 1→0 edge goes to START and resets the tick count.
  - START: after 8 ticks, if the line is still 0 go to DATA; otherwise false start, return to IDLE.
  - DATA: sample every 16 ticks, 8 samples, LSB first.
  - STOP: sample 16 ticks later. If 1, load the rx buffer and set rda=1. If 0 (framing error), discard the byte, leave rda unchanged, and go to IDLE.
  - Then IDLE. A new falling edge is accepted from the cycle after the STOP sample.
- Overrun: a new byte overwrites the rx buffer even if rda=1; rda stays 1.
- Simultaneous RX load and addr-00 read on the same edge: the read returns the old byte, the new byte is stored, and rda stays 1.
- Simultaneous divisor write and tick: the reload from the write wins.

Test Plan:
- Reset: hold rst=0 mid-TX frame, then release → txd=1, tbr=1, rda=0, databus=Z, divisor reads back via a frame at 16'h0516 timing.
- Baud program: write 10←8'h03, 11←8'h00; send 0xA5 → tick every 4 clocks, 64 clocks/bit, txd = 0,1,0,1,0,0,1,0,1,1. tbr is 0 for exactly 1 cycle after the write, then 1.
- Back-to-back TX: write 0x3C, then write 0xC3 while the first frame is in DATA → 20 contiguous bits on txd. A third write issued while tbr=0 is ignored.
- RX: drive 0x5A on rxd at 64 clocks/bit → rda rises after the stop sample. A read of 00 returns 8'h5A and rda=0 after that cycle. A status read of 01 before the read returns 8'h03.
- False start and framing error: a 16-clock low glitch → no rda. A frame with stop bit 0 → rda stays 0, buffer unchanged.
- Overrun and simultaneous: receive 0x11, then 0x22 without reading → read returns 0x22, rda=1 until read. A read of 00 on the same cycle as the load of 0x33 → returns the old byte and rda remains 1.
